// File: rtl/clock_display_mux_pkg.sv
// Shared constants and types for the HH:MM 7-segment display multiplexer.
package clock_display_mux_pkg;

    // Active-low segment glyphs, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // Digit slot index, rightmost first.
    localparam logic [1:0] DIG_MIN0  = 2'd0;
    localparam logic [1:0] DIG_MIN1  = 2'd1;
    localparam logic [1:0] DIG_HOUR0 = 2'd2;
    localparam logic [1:0] DIG_HOUR1 = 2'd3;

    // Per-frame snapshot of the four time digits.
    typedef struct packed {
        logic [1:0] hour1;
        logic [3:0] hour0;
        logic [2:0] min1;
        logic [3:0] min0;
    } digits_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module bcd_to_seg7
    import clock_display_mux_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_n
);

    // Glyph lookup.
    always_comb begin
        seg_n = SEG_DASH;
        case (bcd)
            4'd0:    seg_n = SEG_0;
            4'd1:    seg_n = SEG_1;
            4'd2:    seg_n = SEG_2;
            4'd3:    seg_n = SEG_3;
            4'd4:    seg_n = SEG_4;
            4'd5:    seg_n = SEG_5;
            4'd6:    seg_n = SEG_6;
            4'd7:    seg_n = SEG_7;
            4'd8:    seg_n = SEG_8;
            4'd9:    seg_n = SEG_9;
            default: seg_n = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/clock_display_mux.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment HH:MM display.
// Snapshots the digits once per frame, blanks anodes at slot start to avoid
// ghosting, blinks the colon on digit 2 and optionally hides a leading zero.
module clock_display_mux
    import clock_display_mux_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned BLINK_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] hour1,
    input  logic [3:0] hour0,
    input  logic [2:0] min1,
    input  logic [3:0] min0,
    input  logic       en,
    input  logic       blank_lz,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       dp_n
);

    localparam int unsigned SW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    digits_t       shadow_q, shadow_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic [3:0]    dig_sel;
    logic [6:0]    seg_dec;
    logic          in_blank;
    logic          lz_hide;

    // Slot/index scan, blink timer and frame snapshot next-state.
    always_comb begin
        slot_d      = slot_q + SW'(1);
        idx_d       = idx_q;
        blink_cnt_d = blink_cnt_q + BW'(1);
        blink_d     = blink_q;
        shadow_d    = shadow_q;
        if (slot_q == SW'(DIGIT_CYCLES - 1)) begin
            slot_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end
        if (slot_q == '0 && idx_q == DIG_MIN0) begin
            shadow_d = '{hour1: hour1, hour0: hour0, min1: min1, min0: min0};
        end
    end

    // Select the digit for the current slot; uses the incoming snapshot so the
    // first cycle of a frame already shows the new value.
    always_comb begin
        dig_sel = shadow_d.min0;
        unique case (idx_q)
            DIG_MIN0:  dig_sel = shadow_d.min0;
            DIG_MIN1:  dig_sel = {1'b0, shadow_d.min1};
            DIG_HOUR0: dig_sel = shadow_d.hour0;
            DIG_HOUR1: dig_sel = {2'b00, shadow_d.hour1};
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd   (dig_sel),
        .seg_n (seg_dec)
    );

    // Output next-state: anode blanking, leading-zero hide, colon, enable gate.
    always_comb begin
        in_blank = (slot_q < SW'(BLANK_CYCLES));
        lz_hide  = blank_lz && (idx_q == DIG_HOUR1) && (shadow_d.hour1 == 2'd0);
        an_d     = 4'hF;
        seg_d    = SEG_OFF;
        dp_d     = 1'b1;
        if (en) begin
            seg_d = seg_dec;
            if (!in_blank && !lz_hide) begin
                an_d = ~(4'b0001 << idx_q);
            end
            dp_d = !(blink_q && (idx_q == DIG_HOUR0) && !in_blank);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            idx_q       <= DIG_MIN0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            shadow_q    <= '0;
            an_q        <= 4'hF;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
        end else begin
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            shadow_q    <= shadow_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
        end
    end

    assign an_n  = an_q;
    assign seg_n = seg_q;
    assign dp_n  = dp_q;

endmodule
